// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares the single external memory bus between the I-cache refill port and
//   the D-cache refill/writeback/uncached port. Whole line transactions are
//   granted round-robin, and each grant runs as a burst of word beats. Each beat
//   completes on a mem_ready handshake. A single-word D access is a one-beat
//   transaction.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   ic_req/ic_addr  I-cache refill request and line address (held until done)
//   ic_rdata/valid  beat read data and its qualifier, beat index on ic_beat
//   ic_done         last beat of the I transaction completes this cycle
//   dc_req/we/single/addr/sel
//                   D-cache request, direction, single-word flag, address and
//                   byte enables (sel used only for single-word accesses)
//   dc_wdata        write data for beat dc_beat, looked up in the same cycle
//   dc_rdata/valid  beat read data / write-beat accepted, beat index dc_beat
//   dc_done         last beat of the D transaction completes this cycle
//   mem_*           external bus: ce, we, word address, wdata, byte enables,
//                   rdata and ready (current beat completes)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter  int LINE_WORDS = 8,
  localparam int BW         = $clog2(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  // I-cache refill port
  input  logic          ic_req,
  input  logic [31:0]   ic_addr,
  output logic [31:0]   ic_rdata,
  output logic          ic_valid,
  output logic [BW-1:0] ic_beat,
  output logic          ic_done,
  // D-cache port
  input  logic          dc_req,
  input  logic          dc_we,
  input  logic          dc_single,
  input  logic [31:0]   dc_addr,
  input  logic [3:0]    dc_sel,
  input  logic [31:0]   dc_wdata,
  output logic [31:0]   dc_rdata,
  output logic          dc_valid,
  output logic [BW-1:0] dc_beat,
  output logic          dc_done,
  // External memory bus
  output logic          mem_ce,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_sel,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          last_grant_q, last_grant_d;  // 0 = I won last, 1 = D won last
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic          single_q, single_d;

  logic          pick_i_s;
  logic          pick_d_s;
  logic          granted_s;
  logic          last_beat_s;
  logic          beat_done_s;

  assign granted_s   = (state_q == GNT_I) || (state_q == GNT_D);
  // A single-word access finishes on its first beat regardless of the counter.
  assign last_beat_s = single_q || (beat_q == LAST_BEAT);
  assign beat_done_s = granted_s && mem_ready;

  // Round-robin pick among pending requests; only meaningful while idle.
  always_comb begin
    pick_i_s = 1'b0;
    pick_d_s = 1'b0;
    if (state_q == IDLE) begin
      if (ic_req && dc_req) begin
        // Tie goes to whoever did not win last time.
        pick_d_s = ~last_grant_q;
        pick_i_s = last_grant_q;
      end else begin
        pick_d_s = dc_req;
        pick_i_s = ic_req;
      end
    end else begin
      pick_i_s = 1'b0;
      pick_d_s = 1'b0;
    end
  end

  // Next-state logic: grant from idle, advance beats on ready, return to idle.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    single_d     = single_q;
    case (state_q)
      IDLE: begin
        if (pick_d_s) begin
          state_d      = GNT_D;
          beat_d       = '0;
          last_grant_d = 1'b1;
          addr_d       = dc_addr;
          we_d         = dc_we;
          single_d     = dc_single;
        end else if (pick_i_s) begin
          state_d      = GNT_I;
          beat_d       = '0;
          last_grant_d = 1'b0;
          addr_d       = ic_addr;
          we_d         = 1'b0;
          single_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          if (last_beat_s) begin
            // Forced idle cycle afterwards: no back-to-back grants.
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + {{(BW-1){1'b0}}, 1'b1};
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-burst abandons it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      last_grant_q <= 1'b0;
      addr_q       <= 32'h0000_0000;
      we_q         <= 1'b0;
      single_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      single_q     <= single_d;
    end
  end

  // Bus and per-port outputs; everything is zero while idle.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_sel   = 4'b0000;
    ic_valid  = 1'b0;
    ic_done   = 1'b0;
    ic_beat   = '0;
    dc_valid  = 1'b0;
    dc_done   = 1'b0;
    dc_beat   = '0;
    if (granted_s) begin
      mem_ce = 1'b1;
      mem_we = we_q;
      if (single_q) begin
        mem_addr = {addr_q[31:2], 2'b00};
        mem_sel  = dc_sel;
      end else begin
        mem_addr = {addr_q[31:BW+2], beat_q, 2'b00};
        mem_sel  = 4'b1111;
      end
      // Write data is taken live so the D-cache can look it up by dc_beat.
      if (we_q) begin
        mem_wdata = dc_wdata;
      end else begin
        mem_wdata = 32'h0000_0000;
      end
      if (state_q == GNT_I) begin
        ic_valid = beat_done_s;
        ic_done  = beat_done_s && last_beat_s;
        ic_beat  = beat_q;
      end else begin
        dc_valid = beat_done_s;
        dc_done  = beat_done_s && last_beat_s;
        dc_beat  = beat_q;
      end
    end else begin
      mem_ce = 1'b0;
    end
  end

  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int          LW        = 8;
  localparam int          BW        = $clog2(LW);
  localparam logic [31:0] LINE_MASK = 32'(LW * 4 - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req;
  logic [31:0]   ic_addr;
  logic [31:0]   ic_rdata;
  logic          ic_valid;
  logic [BW-1:0] ic_beat;
  logic          ic_done;
  logic          dc_req;
  logic          dc_we;
  logic          dc_single;
  logic [31:0]   dc_addr;
  logic [3:0]    dc_sel;
  logic [31:0]   dc_wdata;
  logic [31:0]   dc_rdata;
  logic          dc_valid;
  logic [BW-1:0] dc_beat;
  logic          dc_done;
  logic          mem_ce;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_sel;
  logic [31:0]   mem_rdata;
  logic          mem_ready;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_valid(ic_valid),
    .ic_beat(ic_beat), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_single(dc_single), .dc_addr(dc_addr),
    .dc_sel(dc_sel), .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_valid(dc_valid),
    .dc_beat(dc_beat), .dc_done(dc_done),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  // Transaction-level reference: who owns the bus, how many beats are done.
  int          m_owner;     // 0 none, 1 I-cache, 2 D-cache
  int          m_cnt;
  int          m_len;
  logic [31:0] m_base;
  bit          m_we;
  bit          m_single;
  bit          m_prefer_d;
  bit          e_ic_done = 1'b0;
  bit          e_dc_done = 1'b0;
  bit          auto_drop = 1'b0;
  int          done_log[$];
  int          done_cyc[$];

  typedef struct {
    bit          rst;
    bit          req;
    bit          we;
    bit          single;
    bit          ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    bit          x_ce;
    bit          x_we;
    bit          x_valid;
    bit          x_done;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [3:0]  x_sel;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_cnt      = 0;
    m_len      = 0;
    m_base     = 32'h0;
    m_we       = 1'b0;
    m_single   = 1'b0;
    m_prefer_d = 1'b1;
  endtask

  // Call after the falling edge: compare against the model, then advance a clock.
  task automatic tick_now();
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
    bit          e_ce, e_we, e_iv, e_dv, take_d;
    int          e_ib, e_db;
    e_ce = 1'b0; e_we = 1'b0; e_iv = 1'b0; e_dv = 1'b0;
    e_addr = 32'h0; e_wdata = 32'h0; e_sel = 4'h0; e_ib = 0; e_db = 0;
    e_ic_done = 1'b0; e_dc_done = 1'b0;
    if (m_owner != 0) begin
      e_ce    = 1'b1;
      e_we    = m_we;
      e_addr  = m_single ? (m_base & 32'hFFFF_FFFC) : ((m_base & ~LINE_MASK) + 32'(4 * m_cnt));
      e_sel   = m_single ? dc_sel : 4'hF;
      e_wdata = m_we ? dc_wdata : 32'h0;
      if (m_owner == 1) begin
        e_iv = mem_ready; e_ib = m_cnt; e_ic_done = mem_ready && (m_cnt == m_len - 1);
      end else begin
        e_dv = mem_ready; e_db = m_cnt; e_dc_done = mem_ready && (m_cnt == m_len - 1);
      end
    end
    chk("m_mem_ce",    32'(mem_ce),    32'(e_ce));
    chk("m_mem_we",    32'(mem_we),    32'(e_we));
    chk("m_mem_addr",  mem_addr,       e_addr);
    chk("m_mem_wdata", mem_wdata,      e_wdata);
    chk("m_mem_sel",   32'(mem_sel),   32'(e_sel));
    chk("m_ic_valid",  32'(ic_valid),  32'(e_iv));
    chk("m_ic_done",   32'(ic_done),   32'(e_ic_done));
    chk("m_ic_beat",   32'(ic_beat),   32'(e_ib));
    chk("m_dc_valid",  32'(dc_valid),  32'(e_dv));
    chk("m_dc_done",   32'(dc_done),   32'(e_dc_done));
    chk("m_dc_beat",   32'(dc_beat),   32'(e_db));
    chk("m_ic_rdata",  ic_rdata,       mem_rdata);
    chk("m_dc_rdata",  dc_rdata,       mem_rdata);
    if (ic_done === 1'b1) begin done_log.push_back(1); done_cyc.push_back(cyc_no); end
    if (dc_done === 1'b1) begin done_log.push_back(2); done_cyc.push_back(cyc_no); end
    // Advance the reference by one clock.
    if (rst) begin
      model_reset();
    end else if (m_owner == 0) begin
      if (ic_req || dc_req) begin
        take_d     = (ic_req && dc_req) ? m_prefer_d : dc_req;
        m_owner    = take_d ? 2 : 1;
        m_prefer_d = !take_d;
        m_cnt      = 0;
        m_base     = take_d ? dc_addr : ic_addr;
        m_we       = take_d && dc_we;
        m_single   = take_d && dc_single;
        m_len      = m_single ? 1 : LW;
      end
    end else if (mem_ready) begin
      m_cnt++;
      if (m_cnt == m_len) begin
        m_owner = 0;
        m_cnt   = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc_no++;
    if (auto_drop) begin
      if (e_ic_done) ic_req = 1'b0;
      if (e_dc_done) dc_req = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    tick_now();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, bus, done_at, nvalid, ndone, done_beat;
    rst = 1'b1; ic_req = 1'b0; ic_addr = 32'h0; dc_req = 1'b0; dc_we = 1'b0;
    dc_single = 1'b0; dc_addr = 32'h0; dc_sel = 4'h0; dc_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset state
    @(negedge clk);
    chk("rst_mem_ce", 32'(mem_ce), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    tick_now();
    rst = 1'b0;

    // Table: single-word D accesses, latching of addr/we, live sel
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         4'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2000_0006, 32'hCAFE_F00D, 4'h3,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2000_0006, 32'hCAFE_F00D, 4'h3,
              1'b1, 1'b1, 1'b1, 1'b1, 32'h2000_0004, 32'hCAFE_F00D, 4'h3};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_1234, 4'hF,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3000_000B, 32'h5555_5555, 4'hC,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4444_4440, 32'h5555_5555, 4'h3,
              1'b1, 1'b0, 1'b0, 1'b0, 32'h3000_0008, 32'h0,         4'h3};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4444_4440, 32'h5555_5555, 4'h6,
              1'b1, 1'b0, 1'b1, 1'b1, 32'h3000_0008, 32'h0,         4'h6};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         4'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0};
    for (int k = 0; k < 8; k++) begin
      rst = vt[k].rst; dc_req = vt[k].req; dc_we = vt[k].we; dc_single = vt[k].single;
      mem_ready = vt[k].ready; dc_addr = vt[k].addr; dc_wdata = vt[k].wdata;
      dc_sel = vt[k].sel; mem_rdata = $urandom;
      @(negedge clk);
      chk($sformatf("vec%0d_ce", k),    32'(mem_ce),   32'(vt[k].x_ce));
      chk($sformatf("vec%0d_we", k),    32'(mem_we),   32'(vt[k].x_we));
      chk($sformatf("vec%0d_addr", k),  mem_addr,      vt[k].x_addr);
      chk($sformatf("vec%0d_wdata", k), mem_wdata,     vt[k].x_wdata);
      chk($sformatf("vec%0d_sel", k),   32'(mem_sel),  32'(vt[k].x_sel));
      chk($sformatf("vec%0d_valid", k), 32'(dc_valid), 32'(vt[k].x_valid));
      chk($sformatf("vec%0d_done", k),  32'(dc_done),  32'(vt[k].x_done));
      tick_now();
    end
    rst = 1'b0; dc_we = 1'b0; dc_single = 1'b0; dc_sel = 4'h0; dc_wdata = 32'h0;

    // I-cache line refill with an unaligned address
    auto_drop = 1'b1;
    ic_addr = 32'h1000_0024; ic_req = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("t1_idle_ce", 32'(mem_ce), 32'h0);
    tick_now();
    for (int i = 0; i < LW; i++) begin
      @(negedge clk);
      chk("t1_ce",   32'(mem_ce),  32'h1);
      chk("t1_addr", mem_addr,     32'h1000_0020 + 32'(4 * i));
      chk("t1_we",   32'(mem_we),  32'h0);
      chk("t1_done", 32'(ic_done), (i == LW - 1) ? 32'h1 : 32'h0);
      tick_now();
    end
    @(negedge clk);
    chk("t1_after_ce", 32'(mem_ce), 32'h0);
    tick_now();

    // Simultaneous requests after reset alternate D, I, D, I
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      done_log.delete(); done_cyc.delete();
      base = cyc_no;
      ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0; dc_single = 1'b0;
      ic_addr = 32'h1000_0000; dc_addr = 32'h3000_0040;
      for (int i = 0; i < 40 && done_log.size() < 2; i++) cyc();
      chk("t2_count", 32'(done_log.size()), 32'h2);
      if (done_log.size() == 2) begin
        chk("t2_first",  32'(done_log[0]), 32'h2);
        chk("t2_second", 32'(done_log[1]), 32'h1);
        chk("t2_d_cyc",  32'(done_cyc[0] - base), 32'd8);
        chk("t2_i_cyc",  32'(done_cyc[1] - base), 32'd17);
      end
    end

    // D writeback burst with ready alternating 0,1,0,1 on the bus
    dc_req = 1'b1; dc_we = 1'b1; dc_single = 1'b0; dc_addr = 32'h5000_0100;
    mem_ready = 1'b1; dc_wdata = 32'hD000_0000;
    bus = 0; done_at = 0;
    for (int i = 0; i < 40 && done_at == 0; i++) begin
      @(negedge clk);
      if (mem_ce === 1'b1) begin
        bus++;
        chk("t3_wdata", mem_wdata, 32'hD000_0000 + 32'(m_cnt));
      end
      if (dc_done === 1'b1) done_at = bus;
      tick_now();
      mem_ready = ~mem_ready;
      dc_wdata  = 32'hD000_0000 + 32'(m_cnt);
    end
    chk("t3_bus_cycles", 32'(done_at), 32'd16);
    dc_we = 1'b0; mem_ready = 1'b1;
    cyc();

    // Reset at beat 3 of an I burst, then restart from beat 0
    ic_req = 1'b1; ic_addr = 32'h1000_0024; mem_ready = 1'b1;
    repeat (4) cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_beat3", 32'(ic_beat), 32'd3);
    tick_now();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_ce", 32'(mem_ce), 32'h0);
    tick_now();
    @(negedge clk);
    chk("t5_restart_ce",   32'(mem_ce),  32'h1);
    chk("t5_restart_addr", mem_addr,     32'h1000_0020);
    chk("t5_restart_beat", 32'(ic_beat), 32'h0);
    tick_now();
    for (int i = 0; i < 20 && ic_req; i++) cyc();

    // Request dropped at beat 2: the burst still runs to completion
    ic_req = 1'b1; ic_addr = 32'h1800_0000; mem_ready = 1'b1;
    nvalid = 0; ndone = 0; done_beat = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (ic_valid === 1'b1) nvalid++;
      if (ic_done === 1'b1) begin ndone++; done_beat = int'(ic_beat); end
      tick_now();
      if (m_owner == 1 && m_cnt == 2) ic_req = 1'b0;
    end
    chk("t6_beats",     32'(nvalid),    32'd8);
    chk("t6_dones",     32'(ndone),     32'd1);
    chk("t6_done_beat", 32'(done_beat), 32'd7);

    // Randomized traffic against the reference
    auto_drop = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (e_ic_done) ic_req = 1'b0;
      else if (!ic_req) ic_req = ($urandom_range(0, 9) < 3);
      else if (m_owner == 1 && $urandom_range(0, 19) == 0) ic_req = 1'b0;
      if (e_dc_done) dc_req = 1'b0;
      else if (!dc_req) dc_req = ($urandom_range(0, 9) < 3);
      else if (m_owner == 2 && $urandom_range(0, 19) == 0) dc_req = 1'b0;
      ic_addr   = $urandom;
      dc_addr   = $urandom;
      dc_we     = $urandom_range(0, 1);
      dc_single = ($urandom_range(0, 3) == 0);
      dc_sel    = 4'($urandom);
      dc_wdata  = $urandom;
      mem_rdata = $urandom;
      mem_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; mem_ready = 1'b1;
    repeat (12) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
